// File: rtl/windowed_step_accumulator.sv
// Index walks START..STOP; sum accumulates saturating steps while idx<=WIN.
// Optional WINDOW_CHECK_EN adds a window-exit shadow, sticky chk_err output and assertions.
module windowed_step_accumulator #(
  parameter int IDX_W  = 11,
  parameter int SUM_W  = 11,
  parameter int STEP_W = 4,
  parameter int START  = 1,
  parameter int WIN    = 150,
  parameter int STOP   = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  output logic [IDX_W-1:0]  idx,
  output logic [SUM_W-1:0]  sum,
  output logic              in_window,
  output logic              done,
  output logic              ovf
`ifdef WINDOW_CHECK_EN
  ,
  output logic              chk_err
`endif
);

  if (STOP + 1 >= 2 ** IDX_W) begin : g_bad_idx_w
    $error("STOP+1 does not fit in IDX_W");
  end
  if (!(START <= WIN && WIN <= STOP)) begin : g_bad_win
    $error("require START <= WIN <= STOP");
  end

  localparam logic [IDX_W-1:0] START_I = IDX_W'(START);
  localparam logic [IDX_W-1:0] WIN_I   = IDX_W'(WIN);
  localparam logic [IDX_W-1:0] STOP_I  = IDX_W'(STOP);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [SUM_W:0]   sum_ext;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    // One extra bit catches the carry so the result can be clipped instead of wrapping.
    sum_ext = {1'b0, sum_q} + (SUM_W+1)'(step);
    case (state_q)
      IDLE, HOLD: begin
        if (start) begin
          state_d = RUN;
          idx_d   = START_I;
          sum_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (start) begin
          idx_d = START_I;
          sum_d = '0;
          ovf_d = 1'b0;
        end else if (en) begin
          idx_d = idx_q + 1'b1;
          if (idx_q <= WIN_I) begin
            if (sum_ext[SUM_W]) begin
              sum_d = '1;
              ovf_d = 1'b1;
            end else begin
              sum_d = sum_ext[SUM_W-1:0];
            end
          end
          if (idx_q == STOP_I) state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= START_I;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign idx       = idx_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;
  assign done      = done_q;
  assign in_window = (state_q == RUN) && (idx_q <= WIN_I);

`ifdef WINDOW_CHECK_EN
  logic [SUM_W-1:0] shadow_q, shadow_d;
  logic             chk_err_q, chk_err_d;
  logic             win_exit;

  always_comb begin
    // The edge taking idx from WIN to WIN+1 is the last one allowed to change sum.
    win_exit  = (state_q == RUN) && !start && en && (idx_q == WIN_I);
    shadow_d  = win_exit ? sum_d : shadow_q;
    chk_err_d = start ? 1'b0
                      : (chk_err_q | ((idx_q > WIN_I) && (sum_q != shadow_q)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      chk_err_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (idx_q <= STOP_I + 1'b1);
      assert (!done_q || idx_q == STOP_I + 1'b1);
      assert (!(idx_q > WIN_I) || sum_q == shadow_q);
    end
  end
`endif

endmodule
